// File: rtl/ram_copy_engine.sv
// -----------------------------------------------------------------------------
// ram_copy_engine
//   Drives one port of a dual-port RAM to run block jobs. A job either copies
//   i_len words from i_src_addr to i_dst_addr or fills the destination with
//   i_fill_val. A copy reads one word and writes it before reading the next, so
//   the addresses rise strictly. A running checksum (mod 2**DATA_W) of the words
//   written by the current job is kept in o_sum.
//
// Ports
//   clk          in   Clock, rising edge.
//   rst          in   Asynchronous reset, active high.
//   i_start      in   Job request, sampled only in IDLE.
//   i_src_addr   in   Source start address (unused in fill mode).
//   i_dst_addr   in   Destination start address.
//   i_len        in   Word count, 0..2**ADDR_W.
//   i_fill_en    in   1 = fill, 0 = copy.
//   i_fill_val   in   Fill constant.
//   o_busy       out  High in RD, WR and FILL.
//   o_done       out  One-cycle pulse when the job completes.
//   o_sum        out  Checksum of the words written by the last job.
//   o_mem_addr   out  RAM address.
//   o_mem_wdata  out  RAM write data.
//   o_mem_wr     out  RAM write enable.
//   i_mem_rdata  in   RAM read data, registered (valid the cycle after a read).
// -----------------------------------------------------------------------------
module ram_copy_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_src_addr,
  input  logic [ADDR_W-1:0] i_dst_addr,
  input  logic [ADDR_W:0]   i_len,
  input  logic              i_fill_en,
  input  logic [DATA_W-1:0] i_fill_val,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_sum,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_wr,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_FILL,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W:0]   r_remaining;
  logic [DATA_W-1:0] r_fill_val;
  logic [DATA_W-1:0] r_sum;

  // Port values seen in the previous cycle; IDLE and DONE replay them so the
  // RAM port does not toggle between jobs.
  logic [ADDR_W-1:0] r_last_addr;
  logic [DATA_W-1:0] r_last_wdata;

  logic              w_last;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  // The word being written in WR/FILL is the final one of the job.
  assign w_last = (r_remaining == (ADDR_W+1)'(1));

  // NOTE: state is held in flops with async reset and updated with non-blocking
  // assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block gets a default first, otherwise paths that
  // skip an assignment would infer latches.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_len == '0)    w_next_state = S_DONE;
          else if (i_fill_en) w_next_state = S_FILL;
          else                w_next_state = S_RD;
        end
      end
      S_RD:    w_next_state = S_WR;
      S_WR:    w_next_state = w_last ? S_DONE : S_RD;
      S_FILL:  w_next_state = w_last ? S_DONE : S_FILL;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // RAM port decode. Write enable depends only on the state register, so an
  // asynchronous reset drops it immediately.
  always_comb begin
    w_mem_addr  = r_last_addr;
    w_mem_wdata = r_last_wdata;
    o_mem_wr    = 1'b0;
    unique case (r_state)
      S_RD: begin
        w_mem_addr = r_src;
      end
      S_WR: begin
        w_mem_addr  = r_dst;
        w_mem_wdata = i_mem_rdata;
        o_mem_wr    = 1'b1;
      end
      S_FILL: begin
        w_mem_addr  = r_dst;
        w_mem_wdata = r_fill_val;
        o_mem_wr    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src        <= '0;
      r_dst        <= '0;
      r_remaining  <= '0;
      r_fill_val   <= '0;
      r_sum        <= '0;
      r_last_addr  <= '0;
      r_last_wdata <= '0;
    end else begin
      r_last_addr  <= w_mem_addr;
      r_last_wdata <= w_mem_wdata;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_src       <= i_src_addr;
            r_dst       <= i_dst_addr;
            r_remaining <= i_len;
            r_fill_val  <= i_fill_val;
            r_sum       <= '0;
          end
        end
        S_WR: begin
          r_sum       <= r_sum + i_mem_rdata;
          r_src       <= r_src + ADDR_W'(1);
          r_dst       <= r_dst + ADDR_W'(1);
          r_remaining <= r_remaining - (ADDR_W+1)'(1);
        end
        S_FILL: begin
          r_sum       <= r_sum + r_fill_val;
          r_dst       <= r_dst + ADDR_W'(1);
          r_remaining <= r_remaining - (ADDR_W+1)'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_busy      = (r_state == S_RD) || (r_state == S_WR) || (r_state == S_FILL);
  assign o_done      = (r_state == S_DONE);
  assign o_sum       = r_sum;
  assign o_mem_addr  = w_mem_addr;
  assign o_mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_ram_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_ram_copy_engine
//   Bench for ram_copy_engine. A registered-output RAM hangs off the engine
//   port. Expected RAM images and checksums come from a word-by-word model of
//   each job, written directly from the job rules.
// -----------------------------------------------------------------------------
module tb_ram_copy_engine;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] src_addr;
  logic [5:0] dst_addr;
  logic [6:0] len;
  logic       fill_en;
  logic [7:0] fill_val;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_wr;
  logic [7:0] mem_rdata;

  logic [7:0] ram     [64];
  logic [7:0] img     [64];
  logic [7:0] exp_mem [64];
  logic       load_all;

  int         n_checks;
  int         n_fail;
  logic [5:0] wr_addrs[$];

  ram_copy_engine #(.DATA_W(8), .ADDR_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (start),
    .i_src_addr (src_addr),
    .i_dst_addr (dst_addr),
    .i_len      (len),
    .i_fill_en  (fill_en),
    .i_fill_val (fill_val),
    .o_busy     (busy),
    .o_done     (done),
    .o_sum      (sum),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .o_mem_wr   (mem_wr),
    .i_mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-output RAM; load_all copies the bench image in one cycle.
  always @(posedge clk) begin
    if (load_all) begin
      for (int i = 0; i < 64; i++) ram[i] <= img[i];
    end else if (mem_wr) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_image();
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
  endtask

  task automatic load_ram();
    for (int i = 0; i < 64; i++) exp_mem[i] = img[i];
    load_all = 1'b1;
    tick();
    load_all = 1'b0;
  endtask

  // Reference: words move one at a time in ascending order, addresses wrap at 64.
  function automatic logic [7:0] model_job(input int src, input int dst, input int n,
                                           input bit fill, input logic [7:0] fv);
    logic [7:0] s;
    logic [7:0] w;
    s = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = fill ? fv : exp_mem[(src + i) % 64];
      exp_mem[(dst + i) % 64] = w;
      s = s + w;
    end
    return s;
  endfunction

  function automatic int ram_mismatches(output int first);
    int n;
    n = 0;
    first = -1;
    for (int i = 0; i < 64; i++) begin
      if (ram[i] !== exp_mem[i]) begin
        if (first < 0) first = i;
        n++;
      end
    end
    return n;
  endfunction

  // Runs one job; observes from the cycle after the start edge (cycle 1).
  task automatic do_job(input int src, input int dst, input int n, input bit fill,
                        input logic [7:0] fv, output int busy_n, output int done_at,
                        output int wr_n, output logic done_after);
    busy_n   = 0;
    done_at  = -1;
    wr_n     = 0;
    wr_addrs.delete();
    src_addr = 6'(src);
    dst_addr = 6'(dst);
    len      = 7'(n);
    fill_en  = fill;
    fill_val = fv;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    // Changing inputs now must not disturb the running job.
    src_addr = 6'($urandom);
    dst_addr = 6'($urandom);
    len      = 7'($urandom_range(0, 64));
    fill_en  = 1'($urandom);
    fill_val = 8'($urandom);
    for (int c = 1; c <= 300; c++) begin
      if (busy) busy_n++;
      if (mem_wr) begin
        wr_n++;
        wr_addrs.push_back(mem_addr);
      end
      if (done) begin
        done_at = c;
        break;
      end
      tick();
    end
    tick();
    done_after = done;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({busy, done, sum, mem_wr, mem_addr, mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b sum=%h wr=%b addr=%h wdata=%h, want all 0",
               busy, done, sum, mem_wr, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_copy();
    int b, d, w, first, bad;
    logic da;
    logic [7:0] es;
    new_image();
    for (int i = 0; i < 4; i++) img[16 + i] = 8'(i + 1);
    load_ram();
    es = model_job(16, 32, 4, 1'b0, 8'h00);
    do_job(16, 32, 4, 1'b0, 8'h00, b, d, w, da);
    n_checks++;
    if (b !== 8) begin n_fail++; $display("FAIL copy_busy_cycles: got %0d want 8", b); end
    n_checks++;
    if (d !== 9) begin n_fail++; $display("FAIL copy_done_cycle: got %0d want 9", d); end
    n_checks++;
    if (da !== 1'b0) begin n_fail++; $display("FAIL copy_done_width: done=%b after one cycle, want 0", da); end
    n_checks++;
    if (sum !== 8'h0A || sum !== es) begin
      n_fail++; $display("FAIL copy_sum: got %h want 0a (model %h)", sum, es);
    end
    bad = ram_mismatches(first);
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL copy_ram: %0d bad words, first at %0d got %h want %h",
                         bad, first, ram[first], exp_mem[first]);
    end
    repeat (3) tick();
    n_checks++;
    if (sum !== 8'h0A) begin n_fail++; $display("FAIL copy_sum_hold: got %h want 0a", sum); end
  endtask

  task automatic test_fill_wrap();
    int b, d, w, first, bad;
    logic da;
    logic [7:0] es;
    new_image();
    load_ram();
    es = model_job(0, 62, 64, 1'b1, 8'hA5);
    do_job(0, 62, 64, 1'b1, 8'hA5, b, d, w, da);
    n_checks++;
    if (b !== 64 || d !== 65) begin
      n_fail++; $display("FAIL fill_timing: busy %0d done %0d, want 64 and 65", b, d);
    end
    n_checks++;
    if (w !== 64 || wr_addrs.size() < 3 || wr_addrs[0] !== 6'h3E || wr_addrs[1] !== 6'h3F ||
        wr_addrs[2] !== 6'h00) begin
      n_fail++; $display("FAIL fill_wrap_addrs: %0d writes, first %p, want 64 writes from 3e,3f,00",
                         w, wr_addrs[0:2]);
    end
    n_checks++;
    if (sum !== 8'h40 || sum !== es) begin
      n_fail++; $display("FAIL fill_sum: got %h want 40 (model %h)", sum, es);
    end
    bad = ram_mismatches(first);
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL fill_ram: %0d bad words, first at %0d got %h want a5", bad, first, ram[first]);
    end
  endtask

  task automatic test_len_zero();
    int b, d, w, first, bad;
    logic da;
    new_image();
    load_ram();
    do_job(3, 40, 0, 1'b0, 8'h00, b, d, w, da);
    n_checks++;
    if (b !== 0 || d !== 1 || w !== 0) begin
      n_fail++; $display("FAIL len0_timing: busy %0d done %0d writes %0d, want 0 1 0", b, d, w);
    end
    n_checks++;
    if (sum !== 8'h00) begin n_fail++; $display("FAIL len0_sum: got %h want 00", sum); end
    bad = ram_mismatches(first);
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL len0_ram: %0d words changed, first at %0d", bad, first); end
  endtask

  task automatic test_overlap();
    int b, d, w, first, bad;
    logic da;
    logic [7:0] es;
    new_image();
    for (int i = 0; i < 4; i++) img[5 + i] = 8'(10 + i);
    load_ram();
    es = model_job(5, 6, 3, 1'b0, 8'h00);
    do_job(5, 6, 3, 1'b0, 8'h00, b, d, w, da);
    n_checks++;
    if (ram[5] !== 8'h0A || ram[6] !== 8'h0A || ram[7] !== 8'h0A || ram[8] !== 8'h0A) begin
      n_fail++; $display("FAIL overlap_words: got %h %h %h %h want 0a 0a 0a 0a",
                         ram[5], ram[6], ram[7], ram[8]);
    end
    n_checks++;
    if (sum !== 8'h1E || sum !== es) begin n_fail++; $display("FAIL overlap_sum: got %h want 1e", sum); end
    bad = ram_mismatches(first);
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL overlap_ram: %0d bad words, first at %0d", bad, first); end
  endtask

  task automatic test_reset_mid_job();
    int first, bad, dones;
    logic [7:0] es;
    new_image();
    load_ram();
    es = model_job(0, 40, 2, 1'b0, 8'h00);
    src_addr = 6'd0;
    dst_addr = 6'd40;
    len      = 7'd8;
    fill_en  = 1'b0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (mem_wr !== 1'b1 || mem_addr !== 6'd42) begin
      n_fail++; $display("FAIL mid_third_write: wr=%b addr=%0d, want 1 at 42", mem_wr, mem_addr);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({mem_wr, busy, done, sum} !== '0) begin
      n_fail++; $display("FAIL mid_reset_immediate: wr=%b busy=%b done=%b sum=%h, want all 0",
                         mem_wr, busy, done, sum);
    end
    tick();
    rst = 1'b0;
    dones = 0;
    repeat (4) begin
      tick();
      if (done) dones++;
    end
    n_checks++;
    if (dones !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_after_reset: %0d done pulses busy=%b, want 0 and 0", dones, busy);
    end
    bad = ram_mismatches(first);
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL mid_ram: %0d bad words, first at %0d got %h want %h",
                         bad, first, ram[first], exp_mem[first]);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] obs_busy, obs_done;
    logic [7:0] es;
    int d, first, bad;
    new_image();
    load_ram();
    es = model_job(0, 32, 2, 1'b0, 8'h00);
    es = model_job(0, 32, 2, 1'b0, 8'h00);
    src_addr = 6'd0;
    dst_addr = 6'd32;
    len      = 7'd2;
    fill_en  = 1'b0;
    start    = 1'b1;
    tick();
    obs_busy = '0;
    obs_done = '0;
    // Cycles 1..4 busy, done in 5, IDLE in 6, restart busy from 7.
    for (int c = 1; c <= 7; c++) begin
      obs_busy = {obs_busy[5:0], busy};
      obs_done = {obs_done[5:0], done};
      if (c < 7) tick();
    end
    start = 1'b0;
    n_checks++;
    if (obs_busy !== 7'b1111001 || obs_done !== 7'b0000100) begin
      n_fail++; $display("FAIL held_start_seq: busy %b done %b, want 1111001 0000100", obs_busy, obs_done);
    end
    d = -1;
    for (int c = 0; c < 50; c++) begin
      if (done) begin d = c; break; end
      tick();
    end
    tick();
    n_checks++;
    if (d < 0 || sum !== es) begin
      n_fail++; $display("FAIL held_start_second: done seen %0d sum %h, want done and %h", d, sum, es);
    end
    bad = ram_mismatches(first);
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL held_start_ram: %0d bad words, first at %0d", bad, first); end
  endtask

  task automatic test_random_jobs();
    int b, d, w, first, bad, s, t, n, eb;
    bit f;
    logic da;
    logic [7:0] fv, es;
    for (int k = 0; k < 10; k++) begin
      new_image();
      load_ram();
      s  = $urandom_range(0, 63);
      t  = $urandom_range(0, 63);
      n  = (k % 4 == 0) ? $urandom_range(60, 64) : $urandom_range(0, 20);
      f  = 1'($urandom);
      fv = 8'($urandom);
      es = model_job(s, t, n, f, fv);
      eb = f ? n : 2 * n;
      do_job(s, t, n, f, fv, b, d, w, da);
      n_checks++;
      if (b !== eb || d !== eb + 1 || w !== n || da !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_timing: busy %0d done %0d writes %0d, want %0d %0d %0d",
                           k, b, d, w, eb, eb + 1, n);
      end
      n_checks++;
      if (sum !== es) begin n_fail++; $display("FAIL rand%0d_sum: got %h want %h", k, sum, es); end
      bad = ram_mismatches(first);
      n_checks++;
      if (bad != 0) begin
        n_fail++; $display("FAIL rand%0d_ram: %0d bad words, first at %0d got %h want %h",
                           k, bad, first, ram[first], exp_mem[first]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len      = '0;
    fill_en  = 1'b0;
    fill_val = '0;
    load_all = 1'b0;
    for (int i = 0; i < 64; i++) img[i] = 8'h00;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_copy();
    test_fill_wrap();
    test_len_zero();
    test_overlap();
    test_reset_mid_job();
    test_back_to_back();
    test_random_jobs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
